outer_bits_pipe: RTL and testbench



---
 rtl/outer_bits_pkg.sv | 31 +++
 rtl/outer_bits_comb.sv | 50 +++++
 rtl/outer_bits_pipe.sv | 133 +++++++++++++
 tb/tb_outer_bits_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/outer_bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : outer_bits_pkg
// Description : Shared types and helpers for the outer-bits pipeline.
//               The result struct is sized for the largest supported WIDTH
//               (c_MAX_WIDTH). Narrower instances zero-fill the upper bits
//               and consumers slice off the bits they need.
// Revision    : 1.0 - initial release
// ============================================================================
package outer_bits_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_MAX_WIDTH     = 64;

    // Width of a binary index into a word of 'width' bits (at least 1 bit).
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int c_MAX_IDX_W = idx_width(c_MAX_WIDTH);

    typedef struct packed {
        logic [c_MAX_WIDTH-1:0] left;       // one-hot of highest set bit
        logic [c_MAX_WIDTH-1:0] right;      // one-hot of lowest set bit
        logic [c_MAX_IDX_W-1:0] left_idx;   // index of highest set bit
        logic [c_MAX_IDX_W-1:0] right_idx;  // index of lowest set bit
        logic                   zero;       // word was all zeros
    } outer_bits_t;

endpackage : outer_bits_pkg
`default_nettype wire

// File: rtl/outer_bits_comb.sv
`default_nettype none
// ============================================================================
// Module      : outer_bits_comb
// Description : Pure combinational search for the highest and lowest set
//               bits of a WIDTH-bit word (WIDTH <= c_MAX_WIDTH).
// Ports       : data   - input word
//               result - one-hots, indices and zero flag (upper bits 0)
// Revision    : 1.0 - initial release
// ============================================================================
module outer_bits_comb
    import outer_bits_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output outer_bits_t      result
);

    logic [c_MAX_IDX_W-1:0] w_left_idx;
    logic [c_MAX_IDX_W-1:0] w_right_idx;
    logic [c_MAX_WIDTH-1:0] w_hit;
    logic                   w_zero;

    always_comb begin
        w_left_idx  = '0;
        w_right_idx = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) w_left_idx = c_MAX_IDX_W'(i);
        end
        // Descending scan: the last hit is the lowest set bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data[i]) w_right_idx = c_MAX_IDX_W'(i);
        end

        w_zero = ~|data;
        // A single seed bit that vanishes for an all-zero word, so both
        // one-hots come out 0 while the indices stay at their 0 default.
        w_hit  = {{(c_MAX_WIDTH-1){1'b0}}, ~w_zero};

        result           = '0;
        result.left      = w_hit << w_left_idx;
        result.right     = w_hit << w_right_idx;
        result.left_idx  = w_left_idx;
        result.right_idx = w_right_idx;
        result.zero      = w_zero;
    end

endmodule : outer_bits_comb
`default_nettype wire

// File: rtl/outer_bits_pipe.sv
`default_nettype none
// ============================================================================
// Module      : outer_bits_pipe
// Description : Two-stage valid/ready pipeline returning one-hots and
//               indices of the highest and lowest set bits of each word,
//               plus a zero flag. Full backpressure, 1 word/cycle, 2-cycle
//               latency. Optional macro OUTER_BITS_POPCNT_EN adds popcnt_o
//               (number of set bits), registered alongside the other fields.
// Ports       : clk_i, rst_i (async, active-high)
//               data_val_i/data_i/data_ready_o   - producer side
//               data_val_o/data_ready_i          - consumer side
//               data_left_o/data_right_o         - one-hot results
//               left_idx_o/right_idx_o/zero_o    - indices and zero flag
//               popcnt_o                         - only with the macro
// Revision    : 1.0 - initial release
// ============================================================================
module outer_bits_pipe
    import outer_bits_pkg::*;
#(
    parameter  int WIDTH = c_DEFAULT_WIDTH,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             data_ready_o,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic [WIDTH-1:0] data_left_o,
    output logic [WIDTH-1:0] data_right_o,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic             zero_o
`ifdef OUTER_BITS_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt_o
`endif
);

    logic             r_s1_val;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s2_val;
    logic [WIDTH-1:0] r_s2_left;
    logic [WIDTH-1:0] r_s2_right;
    logic [IDX_W-1:0] r_s2_left_idx;
    logic [IDX_W-1:0] r_s2_right_idx;
    logic             r_s2_zero;

    logic             w_adv1;
    logic             w_adv2;
    outer_bits_t      w_res;
    logic             w_unused;

    // A stage may load when it is empty or its contents move on this edge.
    assign w_adv2       = !r_s2_val || data_ready_i;
    assign w_adv1       = !r_s1_val || w_adv2;
    assign data_ready_o = w_adv1;

    outer_bits_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .data   (r_s1_data),
        .result (w_res)
    );

    // Upper (zero-filled) bits of the max-width result are not consumed.
    assign w_unused = &{1'b0, w_res};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_val  <= 1'b0;
            r_s1_data <= '0;
        end else if (w_adv1) begin
            r_s1_val <= data_val_i;
            if (data_val_i) r_s1_data <= data_i;
        end
    end

    // Fields only load with a valid word so they hold while data_val_o=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_val       <= 1'b0;
            r_s2_left      <= '0;
            r_s2_right     <= '0;
            r_s2_left_idx  <= '0;
            r_s2_right_idx <= '0;
            r_s2_zero      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_val <= r_s1_val;
            if (r_s1_val) begin
                r_s2_left      <= w_res.left[WIDTH-1:0];
                r_s2_right     <= w_res.right[WIDTH-1:0];
                r_s2_left_idx  <= w_res.left_idx[IDX_W-1:0];
                r_s2_right_idx <= w_res.right_idx[IDX_W-1:0];
                r_s2_zero      <= w_res.zero;
            end
        end
    end

    assign data_val_o   = r_s2_val;
    assign data_left_o  = r_s2_left;
    assign data_right_o = r_s2_right;
    assign left_idx_o   = r_s2_left_idx;
    assign right_idx_o  = r_s2_right_idx;
    assign zero_o       = r_s2_zero;

`ifdef OUTER_BITS_POPCNT_EN
    localparam int PCNT_W = $clog2(WIDTH + 1);

    logic [PCNT_W-1:0] w_popcnt;
    logic [PCNT_W-1:0] r_s2_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + PCNT_W'(r_s1_data[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_popcnt <= '0;
        end else if (w_adv2 && r_s1_val) begin
            r_s2_popcnt <= w_popcnt;
        end
    end

    assign popcnt_o = r_s2_popcnt;
`endif

endmodule : outer_bits_pipe
`default_nettype wire

// File: tb/tb_outer_bits_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_outer_bits_pipe
// Description : Directed and constrained-random stimulus for outer_bits_pipe
//               at WIDTH=8, with a scoreboard on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outer_bits_pipe;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val;
    logic [7:0] in_data;
    logic       in_rdy;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] left;
    logic [7:0] right;
    logic [2:0] lidx;
    logic [2:0] ridx;
    logic       zero;
`ifdef OUTER_BITS_POPCNT_EN
    logic [3:0] popcnt;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         n_out    = 0;
    bit         last_in_xfer;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    outer_bits_pipe #(
        .WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_val_i   (in_val),
        .data_i       (in_data),
        .data_ready_o (in_rdy),
        .data_val_o   (out_val),
        .data_ready_i (out_rdy),
        .data_left_o  (left),
        .data_right_o (right),
        .left_idx_o   (lidx),
        .right_idx_o  (ridx),
        .zero_o       (zero)
`ifdef OUTER_BITS_POPCNT_EN
        ,
        .popcnt_o     (popcnt)
`endif
    );

    // Reference model: isolate lowest set bit with d & -d; highest set bit
    // by doing the same on the bit-reversed word.
    function automatic logic [7:0] lowbit(input logic [7:0] d);
        return d & (~d + 8'd1);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [7:0] hibit(input logic [7:0] d);
        return rev8(lowbit(rev8(d)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with inputs already driven. Evaluates both
    // transfers just before the rising edge, then returns at the next
    // falling edge.
    task automatic step();
        logic [7:0] e;
        #4;
        last_in_xfer = in_val && in_rdy;
        if (out_val && out_rdy) begin
            n_out++;
            if (q.size() == 0) begin
                chk("sb_extra_output", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_left",  left,  hibit(e));
                chk("sb_right", right, lowbit(e));
                chk("sb_lidx",  lidx,  $clog2(hibit(e)));
                chk("sb_ridx",  ridx,  $clog2(lowbit(e)));
                chk("sb_zero",  zero,  (e == 8'h00));
`ifdef OUTER_BITS_POPCNT_EN
                chk("sb_popcnt", popcnt, $countones(e));
`endif
            end
        end
        if (last_in_xfer) q.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic send_one(input logic [7:0] d, input logic [7:0] el, input logic [7:0] er,
                            input logic [2:0] eli, input logic [2:0] eri, input logic ez);
        in_val  = 1'b1;
        in_data = d;
        out_rdy = 1'b1;
        step();
        in_val = 1'b0;
        chk("lat1_val", out_val, 0);
        step();
        chk("lat2_val", out_val, 1);
        chk("dir_left", left, el);
        chk("dir_right", right, er);
        chk("dir_lidx", lidx, eli);
        chk("dir_ridx", ridx, eri);
        chk("dir_zero", zero, ez);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int sent;
        int cyc;

        rst     = 1'b1;
        in_val  = 1'b0;
        in_data = 8'h00;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_val", out_val, 0);
        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_lidx", lidx, 0);
        chk("rst_ridx", ridx, 0);
        chk("rst_zero", zero, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_rdy, 1);

        // Directed single words
        send_one(8'h06, 8'h04, 8'h02, 3'd2, 3'd1, 1'b0);
        send_one(8'h08, 8'h08, 8'h08, 3'd3, 3'd3, 1'b0);
        send_one(8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1);
        send_one(8'hFF, 8'h80, 8'h01, 3'd7, 3'd0, 1'b0);

        // Back-to-back sweep 0..15: 16 results with no bubble
        out_rdy = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            in_val  = 1'b1;
            in_data = 8'(i);
            step();
        end
        in_val = 1'b0;
        step();
        step();
        chk("sweep_count", n_out - n0, 16);

        // Stall with two words in flight
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_data = 8'h81;
        step();
        in_data = 8'h10;
        step();
        in_val  = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", in_rdy, 0);
            chk("stall_val", out_val, 1);
            chk("stall_left", left, 8'h80);
            chk("stall_right", right, 8'h01);
            step();
        end
        out_rdy = 1'b1;
        step();
        chk("release_val", out_val, 1);
        chk("release_left", left, 8'h10);
        chk("release_right", right, 8'h10);
        step();
        step();

        // Random valid/ready, data held while stalled
        sent = 0;
        cyc  = 0;
        in_val = 1'b0;
        while (sent < 300 && cyc < 20000) begin
            if (!(in_val && !last_in_xfer)) begin
                in_val  = ($urandom_range(0, 2) != 0);
                in_data = 8'($urandom);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
            if (last_in_xfer) sent++;
            cyc++;
        end
        chk("rand_sent", sent, 300);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        repeat (4) step();
        chk("rand_drain", q.size(), 0);

        // Asynchronous reset with two words in flight
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_data = 8'hA5;
        step();
        in_data = 8'h42;
        step();
        in_val = 1'b0;
        chk("pre_rst_val", out_val, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_val", out_val, 0);
        chk("arst_left", left, 0);
        chk("arst_right", right, 0);
        chk("arst_lidx", lidx, 0);
        chk("arst_ridx", ridx, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", in_rdy, 1);
        send_one(8'h3C, 8'h20, 8'h04, 3'd5, 3'd2, 1'b0);

`ifdef OUTER_BITS_POPCNT_EN
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_data = 8'hFF;
        step();
        in_data = 8'h00;
        step();
        in_val = 1'b0;
        chk("popcnt_ff", popcnt, 8);
        step();
        chk("popcnt_00", popcnt, 0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_outer_bits_pipe
`default_nettype wire
